// File: rtl/data_memory_if.sv
// Load/store bus between the RV32I datapath and the data memory.
// The core drives the master side; the memory implements the slave side.
interface data_memory_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic        MisalignErr;
  logic [31:0] ErrAddr;

  modport master (
    output Addr, WriteData, MemRead, MemWrite, Funct3,
    input  ReadData, MisalignErr, ErrAddr
  );

  modport slave (
    input  Addr, WriteData, MemRead, MemWrite, Funct3,
    output ReadData, MisalignErr, ErrAddr
  );
endinterface

// File: rtl/data_memory.sv
// RV32I data memory: combinational sign/zero-extending loads, byte-enabled
// synchronous stores, and sticky capture of the first illegal or misaligned access.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_if.slave bus
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words a 4-byte boundary; other Funct3 codes are illegal.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    case (f3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~lane[0];
      F3_W:        ok = (lane == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              err_q, err_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic [31:0]       wr_word_d;
  logic              wr_en_s;
  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        lane_s;
  logic              legal_s;
  logic              access_s;
  logic [31:0]       rd_word_s;
  logic [7:0]        rd_byte_s;
  logic [15:0]       rd_half_s;
  logic [31:0]       rd_data_s;

  assign idx_s     = bus.Addr[ADDR_W+1:2];
  assign lane_s    = bus.Addr[1:0];
  assign legal_s   = access_ok(bus.Funct3, lane_s);
  assign access_s  = bus.MemRead | bus.MemWrite;
  assign rd_word_s = mem_q[idx_s];
  assign rd_half_s = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];
  assign rd_byte_s = rd_word_s[{lane_s, 3'b000} +: 8];

  // Load path: extend the selected lane; disabled or faulting loads return zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (bus.MemRead && legal_s) begin
      case (bus.Funct3)
        F3_B:    rd_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
        F3_BU:   rd_data_s = {24'h00_0000, rd_byte_s};
        F3_H:    rd_data_s = {{16{rd_half_s[15]}}, rd_half_s};
        F3_HU:   rd_data_s = {16'h0000, rd_half_s};
        F3_W:    rd_data_s = rd_word_s;
        default: rd_data_s = 32'h0000_0000;
      endcase
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Store merge: read-modify-write of the addressed word keeps unselected bytes intact.
  always_comb begin
    wr_word_d = rd_word_s;
    wr_en_s   = bus.MemWrite & legal_s;
    case (bus.Funct3[1:0])
      2'b00:   wr_word_d[{lane_s, 3'b000} +: 8] = bus.WriteData[7:0];
      2'b01: begin
        if (lane_s[1]) begin
          wr_word_d[31:16] = bus.WriteData[15:0];
        end else begin
          wr_word_d[15:0]  = bus.WriteData[15:0];
        end
      end
      2'b10:   wr_word_d = bus.WriteData;
      default: wr_word_d = rd_word_s;
    endcase
  end

  // Fault capture: only the first faulting access is recorded until reset.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (access_s && !legal_s && !err_q) begin
      err_d      = 1'b1;
      err_addr_d = bus.Addr;
    end else begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
    end
  end

  // Storage array: cleared asynchronously, written on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (wr_en_s) begin
      mem_q[idx_s] <= wr_word_d;
    end
  end

  // Sticky status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.ReadData    = rd_data_s;
  assign bus.MisalignErr = err_q;
  assign bus.ErrAddr     = err_addr_q;

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Data memory for the single-cycle RV32I core, directly downstream of the ALU.
- The ALU Result drives Addr. The block serves LB/LH/LW/LBU/LHU with a combinational read, and SB/SH/SW with a synchronous byte-enabled write.
- Detects misaligned and illegal-width accesses and records the first fault in sticky status registers for debug.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
- ADDR_W, 8, log2(DEPTH_WORDS); sets the word-index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Addr  input  32  byte address (ALU Result).
- WriteData  input  32  store data (rs2); the low bytes are used for SB/SH.
- MemRead  input  1  load enable.
- MemWrite  input  1  store enable.
- Funct3  input  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ReadData  output  32  load result, extended to 32 bits.
- MisalignErr  output  1  sticky fault flag.
- ErrAddr  output  32  Addr of the first faulting access.

Behaviour:
- Storage: DEPTH_WORDS x 32 array.
  - Word index = Addr[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
  - Byte lane = Addr[1:0], little-endian.
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - All memory words are cleared to 0.
  - MisalignErr=0, ErrAddr=0.
  - No write is performed while rst_n=0.
  - Reset asserted mid-access aborts that access.
  - ReadData follows the cleared contents combinationally.
- Legality of an access (MemRead|MemWrite):
  - Funct3 in {011,110,111} is illegal.
  - H/HU with Addr[0]=1 is misaligned.
  - W with Addr[1:0]!=0 is misaligned.
  - B/BU are always aligned.
- Read path (combinational, zero latency):
  - MemRead=0 -> ReadData=0.
  - Legal LB/LBU: selected byte, sign-extended / zero-extended.
  - Legal LH/LHU: halfword at Addr[1] (0 = bits 15:0, 1 = bits 31:16), sign-extended / zero-extended.
  - Legal LW: full word.
  - Illegal or misaligned load -> ReadData=0.
- Write path (at posedge clk, only when MemWrite=1 and the access is legal):
  - SB: WriteData[7:0] into lane Addr[1:0].
  - SH: WriteData[15:0] into the half selected by Addr[1].
  - SW: whole word.
  - Unselected bytes are unchanged.
  - Illegal or misaligned stores are suppressed; memory is unchanged.
- Simultaneous MemRead and MemWrite in one cycle:
  - ReadData shows pre-write contents, because the read is combinational before the edge.
  - The write commits at the edge.
  - From the next cycle, ReadData reflects the new data.
- Fault capture (at posedge clk):
  - If (MemRead|MemWrite) and the access is illegal/misaligned and MisalignErr=0, then MisalignErr<=1 and ErrAddr<=Addr.
  - Later faults do not update ErrAddr; the flag is sticky until reset.
  - An illegal Funct3 with both enables low is ignored.
- No handshake: every access completes in the cycle it is presented. No stall output.

Test Plan:
- Reset clear: write SW 0xDEADBEEF @0x10, then pulse rst_n low mid-cycle (no clk edge) -> LW @0x10 returns 0x00000000 immediately; MisalignErr=0, ErrAddr=0.
- Byte/half merge: SW 0x11223344 @0x20; SB WriteData=0xAA @0x21; SH WriteData=0xBEEF @0x22 -> LW @0x20 = 0xBEEFAA44. Then:
  - LB @0x21 = 0xFFFFFFAA, LBU @0x21 = 0x000000AA.
  - LH @0x22 = 0xFFFFBEEF, LHU @0x22 = 0x0000BEEF.
- Misaligned store suppressed and flagged: SW 0x12345678 @0x41 -> word @0x40 unchanged (0). After the edge, MisalignErr=1 and ErrAddr=0x00000041. Next, LH @0x43 -> ReadData=0 and ErrAddr stays 0x41.
- Illegal Funct3: with fresh reset, MemWrite=1, Funct3=011, Addr=0x50, WriteData=0xFFFFFFFF -> memory @0x50 stays 0; MisalignErr=1, ErrAddr=0x50. With MemRead=MemWrite=0 and Funct3=111, the flag does not set.
- Same-cycle read/write and wrap: Addr=0x30 holds 0x0; apply MemRead=MemWrite=1, SW 0xCAFEF00D -> ReadData=0 before the edge and 0xCAFEF00D after. Then SW 0x5A5A5A5A @0x404 (DEPTH_WORDS=256) -> LW @0x004 returns 0x5A5A5A5A.
- Read disabled: MemRead=0 with any Addr and Funct3 -> ReadData=0. After writing 0x80 with SB @0x60, LB @0x60 = 0xFFFFFF80 and LBU = 0x00000080.
